// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default link timing and the
// bit-timer sample-point helper used by receiver and transmitter.
package uart_pkg;

  localparam int unsigned DEF_CLKS_PER_BIT = 32'd16;
  localparam int unsigned DEF_DATA_BITS    = 32'd8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  // Start bit is sampled after half a bit; all later bits one full bit apart.
  function automatic int unsigned mid_count(input int unsigned clks_per_bit,
                                            input logic half_bit);
    int unsigned cmp;
    if (half_bit) begin
      cmp = clks_per_bit / 32'd2 - 32'd1;
    end else begin
      cmp = clks_per_bit - 32'd1;
    end
    return cmp;
  endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Free-running bit timer: counts 0..CLKS_PER_BIT-1, restartable, and flags the
// sample point (half-bit or full-bit compare selected by half_bit).
module uart_baud_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic half_bit,
  output logic mid
);

  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 32'd1);
  localparam logic [TICK_W-1:0] MID_HALF  = TICK_W'(mid_count(CLKS_PER_BIT, 1'b1));
  localparam logic [TICK_W-1:0] MID_FULL  = TICK_W'(mid_count(CLKS_PER_BIT, 1'b0));

  logic [TICK_W-1:0] tick_cnt_r;

  // Tick counter with synchronous restart and wrap at the end of a bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_r <= {TICK_W{1'b0}};
    end else if (restart) begin
      tick_cnt_r <= {TICK_W{1'b0}};
    end else if (tick_cnt_r == TICK_LAST) begin
      tick_cnt_r <= {TICK_W{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_W'(1);
    end
  end

  assign mid = half_bit ? (tick_cnt_r == MID_HALF) : (tick_cnt_r == MID_FULL);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: LSB-first frames with start/stop framing, break hold-off and
// optional parity bit enabled by the UART_RX_PARITY_EN macro.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = DEF_DATA_BITS,
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
`ifdef UART_RX_PARITY_EN
  , parameter bit        PARITY_ODD   = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rxd_data,
  output logic                 rxd_valid,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int BIT_W = $clog2(DATA_BITS + 32'd1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 32'd1);

  uart_state_e          state_r;
  uart_state_e          state_nxt_s;
  logic                 rxd_meta_r;
  logic                 rxd_sync_r;
  logic                 rxd_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_nxt_s;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic                 mid_s;
  logic                 timer_restart_s;
  logic                 timer_half_s;
  logic                 shift_en_s;
  logic                 bit_clr_s;
  logic                 par_en_s;
  logic                 out_load_s;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
    end else begin
      rxd_meta_r <= rxd;
      rxd_sync_r <= rxd_meta_r;
    end
  end

  assign rxd_s        = rxd_sync_r;
  assign timer_half_s = (state_r == ST_START);

  uart_baud_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (timer_restart_s),
    .half_bit(timer_half_s),
    .mid     (mid_s)
  );

  // Next-state and per-cycle strobes.
  always_comb begin
    state_nxt_s     = state_r;
    timer_restart_s = 1'b0;
    shift_en_s      = 1'b0;
    bit_clr_s       = 1'b0;
    par_en_s        = 1'b0;
    out_load_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        timer_restart_s = 1'b1;
        if (!rxd_s) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (mid_s) begin
          // Re-align the timer so data bits are sampled one full bit apart.
          timer_restart_s = 1'b1;
          if (rxd_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DATA;
            bit_clr_s   = 1'b1;
          end
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (mid_s) begin
          shift_en_s = 1'b1;
          if (bit_cnt_r == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nxt_s = ST_PARITY;
`else
            state_nxt_s = ST_STOP;
`endif
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (mid_s) begin
          par_en_s    = 1'b1;
          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_PARITY;
        end
`else
        state_nxt_s = ST_IDLE;
`endif
      end
      ST_STOP: begin
        if (mid_s) begin
          out_load_s = 1'b1;
          if (rxd_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_BREAK;
          end
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (rxd_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BREAK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // New bits enter at the MSB so the first bit ends up at bit 0.
  always_comb begin
    shift_nxt_s                = shift_r >> 1'b1;
    shift_nxt_s[DATA_BITS-1]   = rxd_s;
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      shift_r   <= {DATA_BITS{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
      rxd_data  <= {DATA_BITS{1'b0}};
      rxd_valid <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      rxd_valid <= out_load_s;
      busy      <= (state_nxt_s != ST_IDLE);
      if (shift_en_s) begin
        shift_r <= shift_nxt_s;
      end
      if (bit_clr_s) begin
        bit_cnt_r <= {BIT_W{1'b0}};
      end else if (shift_en_s) begin
        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
      end
      if (out_load_s) begin
        rxd_data  <= shift_r;
        frame_err <= ~rxd_s;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit_r;
  logic parity_err_r;

  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data,
                                           input logic par_bit,
                                           input logic odd);
    return (^data) ^ par_bit ^ odd;
  endfunction

  // Captured parity bit and its check, published with the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bit_r    <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      if (par_en_s) begin
        par_bit_r <= rxd_s;
      end
      if (out_load_s) begin
        parity_err_r <= parity_mismatch(shift_r, par_bit_r, PARITY_ODD);
      end
    end
  end

  assign parity_err = parity_err_r;
`else
  logic unused_par_s;
  assign unused_par_s = par_en_s;
  assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (CLKS_PER_BIT=4, 8 data bits);
// parity scenarios are added when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int CPB = 4;
  localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rxd = 1'b1;
  logic [DB-1:0] rxd_data;
  logic          rxd_valid;
  logic          busy;
  logic          frame_err;
  logic          parity_err;

  int checks   = 0;
  int failures = 0;

  int          cyc            = 0;
  int          valid_cnt      = 0;
  int          last_valid_cyc = 0;
  int          prev_valid_cyc = 0;
  logic [7:0]  data_log [0:63];
  logic        ferr_log [0:63];

  uart_rx #(
    .DATA_BITS   (DB),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rxd_data  (rxd_data),
    .rxd_valid (rxd_valid),
    .busy      (busy),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Pulse monitor sampled on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rxd_valid === 1'b1) begin
      valid_cnt      <= valid_cnt + 1;
      prev_valid_cyc <= last_valid_cyc;
      last_valid_cyc <= cyc;
      if (valid_cnt < 64) begin
        data_log[valid_cnt] <= rxd_data;
        ferr_log[valid_cnt] <= frame_err;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`endif
    send_bit(stop);
  endtask

  task automatic wait_valid(input int target, output bit timeout);
    int n;
    n = 0;
    while (valid_cnt < target && n < 200) begin
      tick(1);
      n++;
    end
    timeout = (valid_cnt < target);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rxd = 1'b1;
    tick(3);
    checks++; if (rxd_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%0h exp=0", rxd_data); end
    checks++; if (rxd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rxd_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
    rst = 1'b0;
    tick(2 * CPB);
  endtask

  task automatic test_basic;
    int base;
    bit to;
    base = valid_cnt;
    send_frame(8'hA5, ^8'hA5, 1'b1);
    wait_valid(base + 1, to);
    checks++; if (to) begin failures++; $display("FAIL basic_timeout got=%0d exp=%0d", valid_cnt, base + 1); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
    tick(CPB);
    checks++; if (valid_cnt !== base + 1) begin failures++; $display("FAIL basic_pulses got=%0d exp=%0d", valid_cnt - base, 1); end
    checks++; if (rxd_data !== 8'hA5) begin failures++; $display("FAIL basic_data got=%0h exp=a5", rxd_data); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL basic_ferr got=%b exp=0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL basic_perr got=%b exp=0", parity_err); end
  endtask

  task automatic test_back_to_back;
    int base;
    bit to;
    base = valid_cnt;
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    wait_valid(base + 2, to);
    tick(CPB);
    checks++; if (valid_cnt !== base + 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", valid_cnt - base); end
    checks++; if (data_log[base] !== 8'h00) begin failures++; $display("FAIL b2b_data0 got=%0h exp=0", data_log[base]); end
    checks++; if (data_log[base + 1] !== 8'hFF) begin failures++; $display("FAIL b2b_data1 got=%0h exp=ff", data_log[base + 1]); end
    checks++; if (last_valid_cyc - prev_valid_cyc !== FRAME_BITS * CPB) begin
      failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", last_valid_cyc - prev_valid_cyc, FRAME_BITS * CPB);
    end
  endtask

  task automatic test_glitch;
    int          base;
    logic [7:0]  prev_data;
    logic        prev_ferr;
    bit          saw_busy;
    base      = valid_cnt;
    prev_data = rxd_data;
    prev_ferr = frame_err;
    saw_busy  = 1'b0;
    rxd = 1'b0;
    tick(1);
    rxd = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    checks++; if (saw_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_pulse got=%b exp=1", saw_busy); end
    checks++; if (valid_cnt !== base) begin failures++; $display("FAIL glitch_no_valid got=%0d exp=0", valid_cnt - base); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
    checks++; if (frame_err !== prev_ferr) begin failures++; $display("FAIL glitch_ferr got=%b exp=%b", frame_err, prev_ferr); end
    checks++; if (rxd_data !== prev_data) begin failures++; $display("FAIL glitch_data got=%0h exp=%0h", rxd_data, prev_data); end
  endtask

  task automatic test_break;
    int base;
    bit to;
    base = valid_cnt;
    send_frame(8'h3C, ^8'h3C, 1'b0);
    rxd = 1'b0;
    tick(2 * CPB);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL break_busy got=%b exp=1", busy); end
    checks++; if (valid_cnt !== base + 1) begin failures++; $display("FAIL break_pulses got=%0d exp=1", valid_cnt - base); end
    checks++; if (data_log[base] !== 8'h3C) begin failures++; $display("FAIL break_data got=%0h exp=3c", data_log[base]); end
    checks++; if (ferr_log[base] !== 1'b1) begin failures++; $display("FAIL break_ferr got=%b exp=1", ferr_log[base]); end
    rxd = 1'b1;
    tick(2 * CPB);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL break_release got=%b exp=0", busy); end
    send_frame(8'h11, ^8'h11, 1'b1);
    wait_valid(base + 2, to);
    checks++; if (to) begin failures++; $display("FAIL break_next_timeout got=%0d exp=%0d", valid_cnt, base + 2); end
    checks++; if (rxd_data !== 8'h11) begin failures++; $display("FAIL break_next_data got=%0h exp=11", rxd_data); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL break_next_ferr got=%b exp=0", frame_err); end
  endtask

  task automatic test_reset_mid_frame;
    int         base;
    bit         to;
    logic [7:0] d;
    d    = 8'hC3;
    base = valid_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (rxd_data !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%0h exp=0", rxd_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (rxd_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", rxd_valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rstmid_ferr got=%b exp=0", frame_err); end
    rxd = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2 * CPB);
    checks++; if (valid_cnt !== base) begin failures++; $display("FAIL rstmid_no_valid got=%0d exp=0", valid_cnt - base); end
    send_frame(8'h5A, ^8'h5A, 1'b1);
    wait_valid(base + 1, to);
    checks++; if (to) begin failures++; $display("FAIL rstmid_timeout got=%0d exp=%0d", valid_cnt, base + 1); end
    checks++; if (rxd_data !== 8'h5A) begin failures++; $display("FAIL rstmid_data_after got=%0h exp=5a", rxd_data); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rstmid_ferr_after got=%b exp=0", frame_err); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int base;
    bit to;
    base = valid_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    wait_valid(base + 1, to);
    checks++; if (to) begin failures++; $display("FAIL par_good_timeout got=%0d exp=%0d", valid_cnt, base + 1); end
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL par_good got=%b exp=0", parity_err); end
    tick(CPB);
    send_frame(8'h07, 1'b0, 1'b1);
    wait_valid(base + 2, to);
    checks++; if (to) begin failures++; $display("FAIL par_bad_timeout got=%0d exp=%0d", valid_cnt, base + 2); end
    checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL par_bad got=%b exp=1", parity_err); end
    checks++; if (rxd_data !== 8'h07) begin failures++; $display("FAIL par_bad_data got=%0h exp=07", rxd_data); end
    tick(CPB);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    tick(2 * CPB);
    test_glitch();
    test_break();
    tick(CPB);
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    tick(CPB);
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
